result_capture: RTL

RESULT_CAPTURE -- requirements
Module: result_capture

---
 rtl/result_capture_pkg.sv | 25 ++
 rtl/capture_fifo.sv | 79 +++++++
 rtl/result_capture.sv | 123 ++++++++++++
 3 files changed

// File: rtl/result_capture_pkg.sv
// ============================================================================
//  Module      : result_capture_pkg
//  Description : Shared constants and helpers for the result_capture block.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package result_capture_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 16;
  localparam int STAMP_W       = 16;
  localparam int DROP_W        = 8;

  // Increment that sticks at all-ones instead of wrapping back to zero.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    if (v == {DROP_W{1'b1}}) begin
      return v;
    end
    return v + {{(DROP_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

`default_nettype wire

// File: rtl/capture_fifo.sv
// ============================================================================
//  Module      : capture_fifo
//  Description : Synchronous-write, registered-read FIFO with wrap-around
//                pointers and an explicit occupancy counter. A push while
//                full is accepted only when a pop frees the head slot in the
//                same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module capture_fifo #(
  parameter int  DEPTH = 16,
  parameter int  DW    = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_wr_en,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_rd_en,
  output logic [DW-1:0] o_rd_data,
  output logic          o_rd_valid,
  output logic [CW-1:0] o_count,
  output logic          o_empty,
  output logic          o_full
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [DW-1:0] r_rd_data;
  logic          r_rd_valid;

  logic w_pop;
  logic w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign w_pop   = i_rd_en && !o_empty;
  // A simultaneous pop vacates the head, so a full FIFO can still take the write.
  assign w_push  = i_wr_en && (!o_full || w_pop);

  // Storage array: written on push, never reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointers, occupancy and the registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_pop;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + AW'(1);
        r_rd_data <= r_mem[r_rd_ptr];
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_rd_valid;
  assign o_count    = r_count;

endmodule

`default_nettype wire

// File: rtl/result_capture.sv
// ============================================================================
//  Module      : result_capture
//  Description : Monitors a processor result bus and queues every new value
//                (first sample after enable, then each change) into a FIFO.
//                Captures that find the FIFO full are dropped and counted.
//                Optional macro RESULT_CAPTURE_TIMESTAMP_EN adds a 16-bit
//                free-running cycle stamp stored with each entry (rd_stamp).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module result_capture
  import result_capture_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       salida_in,
  input  logic                   cap_en,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_cnt
`ifdef RESULT_CAPTURE_TIMESTAMP_EN
  ,
  output logic [STAMP_W-1:0]     rd_stamp
`endif
);

`ifdef RESULT_CAPTURE_TIMESTAMP_EN
  localparam int FW = WIDTH + STAMP_W;
`else
  localparam int FW = WIDTH;
`endif

  logic [WIDTH-1:0]  r_last;
  logic              r_seen;
  logic              r_overflow;
  logic [DROP_W-1:0] r_drop_cnt;

  logic          w_cap;
  logic          w_pop;
  logic          w_drop;
  logic [FW-1:0] w_wr_word;
  logic [FW-1:0] w_rd_word;

  // A capture is the first sample after enabling, or any change of value.
  assign w_cap  = cap_en && (!r_seen || (salida_in != r_last));
  assign w_pop  = rd_en && !empty;
  assign w_drop = w_cap && full && !w_pop;

`ifdef RESULT_CAPTURE_TIMESTAMP_EN
  logic [STAMP_W-1:0] r_stamp;

  // Free-running cycle counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stamp <= '0;
    end else begin
      r_stamp <= r_stamp + STAMP_W'(1);
    end
  end

  assign w_wr_word = {r_stamp, salida_in};
  assign rd_stamp  = w_rd_word[FW-1:WIDTH];
`else
  assign w_wr_word = salida_in;
`endif

  assign rd_data = w_rd_word[WIDTH-1:0];

  // Change-detection state: last captured word and first-sample flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= '0;
      r_seen <= 1'b0;
    end else if (!cap_en) begin
      r_seen <= 1'b0;
    end else if (w_cap) begin
      r_seen <= 1'b1;
      r_last <= salida_in;
    end
  end

  // Sticky overflow and saturating drop counter; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      r_drop_cnt <= sat_inc(r_drop_cnt);
    end
  end

  assign overflow = r_overflow;
  assign drop_cnt = r_drop_cnt;

  capture_fifo #(
    .DEPTH (DEPTH),
    .DW    (FW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_wr_en    (w_cap),
    .i_wr_data  (w_wr_word),
    .i_rd_en    (rd_en),
    .o_rd_data  (w_rd_word),
    .o_rd_valid (rd_valid),
    .o_count    (count),
    .o_empty    (empty),
    .o_full     (full)
  );

endmodule

`default_nettype wire
